// File: rtl/vmcmp_accum.sv
// vmcmp_accum: element-wise vector compare at SEW 8/16/32/64, packing mask bits into DATA_WIDTH-bit words.
// Optional macro VMCMP_VM_MASK_EN adds the per-element active mask input in_vm.
module vmcmp_accum #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int OPSEL_WIDTH = 3,
   parameter int PTR_WIDTH   = $clog2(DATA_WIDTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_first,
   input  logic                      in_last,
   input  logic [ADDR_WIDTH-1:0]     in_addr,
   input  logic [DATA_WIDTH-1:0]     in_vec0,
   input  logic [DATA_WIDTH-1:0]     in_vec1,
   input  logic [1:0]                in_sew,
   input  logic [OPSEL_WIDTH-1:0]    in_opSel,
`ifdef VMCMP_VM_MASK_EN
   input  logic [DATA_WIDTH/8-1:0]   in_vm,
`endif
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ADDR_WIDTH-1:0]     out_addr,
   output logic [DATA_WIDTH-1:0]     out_vec,
   output logic [DATA_WIDTH/8-1:0]   out_be
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic adv;

   logic                   s0_valid, s0_first, s0_last;
   logic [DATA_WIDTH-1:0]  s0_vec0, s0_vec1;
   logic [ADDR_WIDTH-1:0]  s0_addr;
   logic [1:0]             s0_sew;
   logic [OPSEL_WIDTH-1:0] s0_op;
   logic [BE_WIDTH-1:0]    s0_vm;

   logic                   s1_valid, s1_first, s1_last;
   logic [DATA_WIDTH-1:0]  s1_bits;
   logic [ADDR_WIDTH-1:0]  s1_addr;
   logic [1:0]             s1_sew;

   logic [DATA_WIDTH-1:0]  acc;
   logic [BE_WIDTH-1:0]    be_acc;
   logic [PTR_WIDTH-1:0]   ptr;
   logic [ADDR_WIDTH-1:0]  word_addr;

   logic [PTR_WIDTH:0]     n_elems;
   logic [PTR_WIDTH-1:0]   ptr_eff;
   logic [DATA_WIDTH-1:0]  acc_base, field, merged_vec;
   logic [BE_WIDTH-1:0]    be_base, merged_be;
   logic [PTR_WIDTH:0]     end_pos;
   logic                   flush;
   logic [ADDR_WIDTH-1:0]  addr_eff;

   logic [DATA_WIDTH-1:0]  cmp_by_sew [4];

   function automatic logic cmp_op(input logic [2:0] op, input logic eq,
                                   input logic ltu, input logic lt);
      case (op)
         3'b000:  cmp_op = eq;
         3'b001:  cmp_op = !eq;
         3'b010:  cmp_op = ltu;
         3'b011:  cmp_op = lt;
         3'b100:  cmp_op = ltu | eq;
         3'b101:  cmp_op = lt | eq;
         3'b110:  cmp_op = !(ltu | eq);
         default: cmp_op = !(lt | eq);
      endcase
   endfunction

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_first <= 1'b0;
         s0_last  <= 1'b0;
         s0_vec0  <= '0;
         s0_vec1  <= '0;
         s0_addr  <= '0;
         s0_sew   <= '0;
         s0_op    <= '0;
      end else if (adv) begin
         s0_valid <= in_valid;
         if (in_valid) begin
            s0_first <= in_first;
            s0_last  <= in_last;
            s0_vec0  <= in_vec0;
            s0_vec1  <= in_vec1;
            s0_addr  <= in_addr;
            if (in_first) begin
               s0_sew <= in_sew;
               s0_op  <= in_opSel;
            end
         end
      end
   end

`ifdef VMCMP_VM_MASK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         s0_vm <= '0;
      else if (adv && in_valid)
         s0_vm <= in_vm;
   end
`else
   assign s0_vm = '1;
`endif

   // One comparator bank per element width; the registered sew picks which bank feeds S1.
   for (genvar g = 0; g < 4; g++) begin : g_sew
      localparam int W  = 8 << g;
      localparam int NE = DATA_WIDTH / W;
      logic [NE-1:0] res;
      for (genvar e = 0; e < NE; e++) begin : g_elem
         logic [W-1:0] a, b;
         assign a      = s0_vec0[e*W +: W];
         assign b      = s0_vec1[e*W +: W];
         assign res[e] = cmp_op(s0_op[2:0], a == b, a < b, $signed(a) < $signed(b)) & s0_vm[e];
      end
      assign cmp_by_sew[g] = {{(DATA_WIDTH-NE){1'b0}}, res};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_bits  <= '0;
         s1_addr  <= '0;
         s1_sew   <= '0;
      end else if (adv) begin
         s1_valid <= s0_valid;
         s1_first <= s0_first;
         s1_last  <= s0_last;
         s1_bits  <= cmp_by_sew[s0_sew];
         s1_addr  <= s0_addr;
         s1_sew   <= s0_sew;
      end
   end

   always_comb begin
      case (s1_sew)
         2'd0:    n_elems = (PTR_WIDTH+1)'(DATA_WIDTH / 8);
         2'd1:    n_elems = (PTR_WIDTH+1)'(DATA_WIDTH / 16);
         2'd2:    n_elems = (PTR_WIDTH+1)'(DATA_WIDTH / 32);
         default: n_elems = (PTR_WIDTH+1)'(DATA_WIDTH / 64);
      endcase
   end

   // A first beat starts a fresh word, silently dropping any unterminated partial word.
   always_comb begin
      ptr_eff    = s1_first ? '0 : ptr;
      acc_base   = s1_first ? '0 : acc;
      be_base    = s1_first ? '0 : be_acc;
      field      = ~({DATA_WIDTH{1'b1}} << n_elems) << ptr_eff;
      merged_vec = acc_base | (s1_bits << ptr_eff);
      merged_be  = be_base;
      for (int j = 0; j < BE_WIDTH; j++) begin
         if (|field[j*8 +: 8])
            merged_be[j] = 1'b1;
      end
      end_pos  = {1'b0, ptr_eff} + n_elems;
      flush    = (end_pos == (PTR_WIDTH+1)'(DATA_WIDTH)) || s1_last;
      addr_eff = (ptr_eff == '0) ? s1_addr : word_addr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         be_acc    <= '0;
         ptr       <= '0;
         word_addr <= '0;
         out_valid <= 1'b0;
         out_vec   <= '0;
         out_be    <= '0;
         out_addr  <= '0;
      end else if (adv) begin
         out_valid <= s1_valid && flush;
         if (s1_valid) begin
            word_addr <= addr_eff;
            if (flush) begin
               out_vec  <= merged_vec;
               out_be   <= merged_be;
               out_addr <= addr_eff;
               acc      <= '0;
               be_acc   <= '0;
               ptr      <= '0;
            end else begin
               acc    <= merged_vec;
               be_acc <= merged_be;
               ptr    <= end_pos[PTR_WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_vmcmp_accum.sv
// tb_vmcmp_accum: directed and randomized stimulus for vmcmp_accum, scored against a word-level model.
// Honours VMCMP_VM_MASK_EN when the design is built with it.
module tb_vmcmp_accum;

   localparam int DW = 64;
   localparam int AW = 32;
   localparam int OW = 3;
   localparam int BW = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_first = 1'b0;
   logic          in_last = 1'b0;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_vec0 = '0;
   logic [DW-1:0] in_vec1 = '0;
   logic [1:0]    in_sew = '0;
   logic [OW-1:0] in_opSel = '0;
   logic [BW-1:0] in_vm = '1;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_vec;
   logic [BW-1:0] out_be;

   vmcmp_accum #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPSEL_WIDTH(OW)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_first(in_first),
      .in_last(in_last),
      .in_addr(in_addr),
      .in_vec0(in_vec0),
      .in_vec1(in_vec1),
      .in_sew(in_sew),
      .in_opSel(in_opSel),
`ifdef VMCMP_VM_MASK_EN
      .in_vm(in_vm),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_addr(out_addr),
      .out_vec(out_vec),
      .out_be(out_be)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] vec;
      logic [BW-1:0] be;
      logic [AW-1:0] addr;
   } word_t;

   word_t exp_q[$];
   int    checks = 0;
   int    failures = 0;

   // Model state: mask bits collected so far for the word under construction.
   logic [1:0]    m_sew = '0;
   logic [2:0]    m_op = '0;
   int            m_ptr = 0;
   logic [DW-1:0] m_acc = '0;
   logic [BW-1:0] m_be = '0;
   logic [AW-1:0] m_addr = '0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
      end
   endtask

   function automatic logic elemCompare(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input int w);
      longint sa, sb;
      sa = (w < 64 && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = (w < 64 && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
      case (op)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd2:    return a < b;
         3'd3:    return sa < sb;
         3'd4:    return a <= b;
         3'd5:    return sa <= sb;
         3'd6:    return a > b;
         default: return sa > sb;
      endcase
   endfunction

   task automatic modelReset();
      m_sew = '0; m_op = '0; m_ptr = 0; m_acc = '0; m_be = '0; m_addr = '0;
      exp_q.delete();
   endtask

   task automatic modelBeat(input logic first, input logic last, input logic [1:0] sew, input logic [2:0] op,
                            input logic [AW-1:0] addr, input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                            input logic [BW-1:0] vm);
      int w, n;
      logic [63:0] a, b, msk;
      word_t wd;
      if (first) begin
         m_sew = sew; m_op = op; m_ptr = 0; m_acc = '0; m_be = '0;
      end
      w = 8 << m_sew;
      n = DW / w;
      if (m_ptr == 0) m_addr = addr;
      msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      for (int i = 0; i < n; i++) begin
         a = (v0 >> (i * w)) & msk;
         b = (v1 >> (i * w)) & msk;
         m_acc[m_ptr + i] = elemCompare(m_op, a, b, w) & vm[i];
         m_be[(m_ptr + i) / 8] = 1'b1;
      end
      m_ptr += n;
      if (m_ptr == DW || last) begin
         wd.vec = m_acc; wd.be = m_be; wd.addr = m_addr;
         exp_q.push_back(wd);
         m_ptr = 0; m_acc = '0; m_be = '0;
      end
   endtask

   // Mid-cycle monitor: score the output register against the model and feed accepted beats into it.
   always @(negedge clk) begin
      if (rst) begin
         modelReset();
      end else begin
         checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_word actual=0x%0h required=none", out_vec);
            end else begin
               checkOutput("sb_vec", out_vec, exp_q[0].vec);
               checkOutput("sb_be", out_be, exp_q[0].be);
               checkOutput("sb_addr", out_addr, exp_q[0].addr);
               if (out_ready) exp_q.delete(0);
            end
         end
         if (in_valid && in_ready) begin
`ifdef VMCMP_VM_MASK_EN
            modelBeat(in_first, in_last, in_sew, in_opSel, in_addr, in_vec0, in_vec1, in_vm);
`else
            modelBeat(in_first, in_last, in_sew, in_opSel, in_addr, in_vec0, in_vec1, '1);
`endif
         end
      end
   end

   task automatic applyStimulus(input logic first, input logic last, input logic [1:0] sew, input logic [2:0] op,
                                input logic [AW-1:0] addr, input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                                input logic [BW-1:0] vm);
      int  budget;
      logic took;
      in_valid = 1'b1; in_first = first; in_last = last; in_sew = sew; in_opSel = op;
      in_addr = addr; in_vec0 = v0; in_vec1 = v1; in_vm = vm;
      budget = 0;
      took = 1'b0;
      while (!took && budget < 200) begin
         @(negedge clk);
         took = in_ready && !rst;
         @(posedge clk);
         #1;
         budget++;
      end
      if (!took) begin
         checks++;
         failures++;
         $display("[TB] FAIL beat_accept actual=stalled required=accepted");
      end
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
   endtask

   task automatic waitWord(output logic [DW-1:0] v, output logic [BW-1:0] be, output logic [AW-1:0] a);
      logic seen;
      seen = 1'b0;
      v = 'x; be = 'x; a = 'x;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            seen = 1'b1; v = out_vec; be = out_be; a = out_addr;
         end
      end
      checkOutput("word_seen", seen, 1'b1);
      @(posedge clk);
      #1;
   endtask

   localparam logic [DW-1:0] PAT = 64'h0123_4567_89AB_CDEF;

   logic [DW-1:0] wv;
   logic [BW-1:0] wb;
   logic [AW-1:0] wa;
   logic          rand_done;

   initial begin
      #2;
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_out_vec", out_vec, 64'h0);
      checkOutput("reset_out_be", out_be, 8'h0);
      checkOutput("reset_in_ready", in_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Single-beat instruction: latency and literal result.
      applyStimulus(1, 1, 2'd0, 3'b000, 'h100, PAT, PAT, '1);
      @(posedge clk); #1;
      checkOutput("latency_edge1", out_valid, 1'b0);
      @(posedge clk); #1;
      checkOutput("latency_edge2", out_valid, 1'b1);
      checkOutput("t1_vec", out_vec, 64'hFF);
      checkOutput("t1_be", out_be, 8'h01);
      checkOutput("t1_addr", out_addr, 'h100);
      @(posedge clk); #1;
      checkOutput("t1_pulse_end", out_valid, 1'b0);

      // Signed versus unsigned compare on byte 0 (0x80 vs 0x01).
      applyStimulus(1, 1, 2'd0, 3'b011, 'h10, 64'h1111_1111_1111_1180, 64'h1111_1111_1111_1101, '1);
      waitWord(wv, wb, wa);
      checkOutput("lt_signed", wv, 64'h01);
      applyStimulus(1, 1, 2'd0, 3'b010, 'h10, 64'h1111_1111_1111_1180, 64'h1111_1111_1111_1101, '1);
      waitWord(wv, wb, wa);
      checkOutput("ltu_unsigned", wv, 64'h00);
      applyStimulus(1, 1, 2'd0, 3'b111, 'h10, 64'h1111_1111_1111_1180, 64'h1111_1111_1111_1101, '1);
      waitWord(wv, wb, wa);
      checkOutput("gt_signed", wv, 64'h00);

      // SEW16 three-beat instruction.
      for (int b = 1; b <= 3; b++)
         applyStimulus(b == 1, b == 3, 2'd1, 3'b000, 'h40, PAT, PAT, '1);
      waitWord(wv, wb, wa);
      checkOutput("sew16_vec", wv, 64'hFFF);
      checkOutput("sew16_be", wb, 8'h03);
      checkOutput("sew16_addr", wa, 'h40);
      checkOutput("sew16_single_pulse", out_valid, 1'b0);

      // Nine SEW8 beats: full-word flush then last-beat flush.
      for (int b = 1; b <= 9; b++)
         applyStimulus(b == 1, b == 9, 2'd0, 3'b000, (b == 9) ? 'h8 : 'h0, PAT, PAT, '1);
      waitWord(wv, wb, wa);
      checkOutput("full_vec", wv, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("full_be", wb, 8'hFF);
      checkOutput("full_addr", wa, 'h0);
      waitWord(wv, wb, wa);
      checkOutput("tail_vec", wv, 64'hFF);
      checkOutput("tail_be", wb, 8'h01);
      checkOutput("tail_addr", wa, 'h8);

      // Backpressure: consumer stalls while single-beat words stream in.
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               applyStimulus(1, 1, 2'd0, 3'b000, 'h200 + 8 * i, PAT, PAT ^ (64'h01 << (8 * i)), '1);
         end
         begin
            logic seen_bp;
            seen_bp = 1'b0;
            for (int c = 0; c < 20 && !seen_bp; c++) begin
               @(negedge clk);
               seen_bp = out_valid;
            end
            checkOutput("bp_valid_seen", seen_bp, 1'b1);
            for (int c = 0; c < 4; c++) begin
               checkOutput("bp_in_ready", in_ready, 1'b0);
               checkOutput("bp_vec_hold", out_vec, 64'hFE);
               checkOutput("bp_addr_hold", out_addr, 'h200);
               @(negedge clk);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (10) @(posedge clk);
      #1;

      // Reset in the middle of an instruction.
      applyStimulus(1, 0, 2'd0, 3'b000, 'h300, PAT, PAT, '1);
      applyStimulus(0, 0, 2'd0, 3'b000, 'h300, PAT, PAT, '1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_out_valid", out_valid, 1'b0);
      checkOutput("midrst_out_vec", out_vec, 64'h0);
      checkOutput("midrst_out_be", out_be, 8'h0);
      checkOutput("midrst_out_addr", out_addr, 'h0);
      checkOutput("midrst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;
      applyStimulus(1, 1, 2'd0, 3'b000, 'h400, PAT, PAT, '1);
      waitWord(wv, wb, wa);
      checkOutput("postrst_vec", wv, 64'hFF);
      checkOutput("postrst_be", wb, 8'h01);
      checkOutput("postrst_addr", wa, 'h400);
      // A last-only beat after reset uses the cleared sew/op (SEW8, eq) and an empty word.
      applyStimulus(0, 1, 2'd3, 3'b111, 'h500, PAT, PAT, '1);
      waitWord(wv, wb, wa);
      checkOutput("postrst_lastonly_vec", wv, 64'hFF);
      checkOutput("postrst_lastonly_addr", wa, 'h500);

      // Randomized traffic with random consumer stalls.
      rand_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               logic [DW-1:0] v0, v1;
               v0 = {$urandom, $urandom};
               v1 = v0;
               for (int j = 0; j < BW; j++)
                  if ($urandom_range(0, 1) == 0) v1[j*8 +: 8] = 8'($urandom);
               applyStimulus((k == 0) || ($urandom_range(0, 5) == 0), $urandom_range(0, 4) == 0,
                             2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                             AW'($urandom), v0, v1, BW'($urandom));
               if ($urandom_range(0, 4) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            applyStimulus(0, 1, 2'd0, 3'b000, 'h0, PAT, PAT, '1);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join

      for (int c = 0; c < 100 && (exp_q.size() != 0 || out_valid); c++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("drain_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
